// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: opcode field layout and fetch FSM encodings shared by fetch and decode
package instruction_fetch_pkg;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int JT_W = 10;
  localparam logic [3:0] OP_JUMP = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;
  function automatic logic [3:0] opcode(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/instruction_fetch_next_pc.sv
// fetch_next_pc: next program counter, priority reset > redirect > hold > jump > halt-hold > increment
module fetch_next_pc #(
  parameter int N = 10,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         rst,
  input  logic         redirect,
  input  logic         load,
  input  logic         jump,
  input  logic         halt,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] redirect_target,
  input  logic [N-1:0] jump_target,
  output logic [N-1:0] next_pc
);
  always_comb
    next_pc = rst ? RESET_PC : redirect ? redirect_target : !load ? pc :
              jump ? jump_target : halt ? pc : pc + N'(1);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-entry fetch stage with stall, redirect and HALT handling.
// Define FETCH_JUMP_PREDECODE_EN to resolve JUMP opcodes in fetch with a one-cycle bubble.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int N = 10,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] pm_addr,
  input  logic [15:0]  pm_data,
  output logic [15:0]  instr_out,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic         halted
);
  logic [0:0] state;
  logic [N-1:0] pc, next_pc, jump_target;
  logic fetching, redirect, load, is_halt, is_jump;
  always_comb begin
    fetching = state == S_FETCH;
    redirect = fetching && redirect_valid;
    load = fetching && (!instr_valid || instr_ready) && !redirect_valid;
    is_halt = opcode(pm_data) == OP_HALT;
`ifdef FETCH_JUMP_PREDECODE_EN
    is_jump = opcode(pm_data) == OP_JUMP;
`else
    is_jump = 1'b0;
`endif
    jump_target = N'(pm_data[JT_W-1:0]);
  end
  assign pm_addr = pc;
  assign halted = state == S_HALTED;
  fetch_next_pc #(.N(N), .RESET_PC(RESET_PC)) u_next_pc (
    .rst(rst),
    .redirect(redirect),
    .load(load),
    .jump(is_jump),
    .halt(is_halt),
    .pc(pc),
    .redirect_target(redirect_target),
    .jump_target(jump_target),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk) begin
    pc <= next_pc;
    if (rst) begin
      state <= S_FETCH;
      instr_out <= 16'h0000;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_valid <= !is_jump;
      if (!is_jump) begin
        instr_out <= pm_data;
        instr_pc <= pc;
        if (is_halt) state <= S_HALTED;
      end
    end else if (!fetching && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end
endmodule
